// File: rtl/mmio_bridge.sv
// Data-memory splitter: routes core accesses to external RAM or to the on-chip
// peripheral window (LEDs, debounced switches, timer with compare and sticky IRQ flag).
module mmio_bridge #(
  parameter int unsigned SW_W      = 16,
  parameter int unsigned LED_W     = 16,
  parameter logic [19:0] DEB_CYC   = 20'd500000,
  parameter logic [31:0] MMIO_BASE = 32'hBFAF_F000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              dram_ce_o,
  output logic              dram_we_o,
  output logic [31:0]       dram_addr_o,
  output logic [31:0]       dram_wdata_o,
  input  logic [31:0]       dram_rdata_i,
  input  logic [SW_W-1:0]   switch_on,
  output logic [LED_W-1:0]  led_out,
  output logic              timer_irq_o
);

  localparam logic [7:0] OFF_LED  = 8'h00;
  localparam logic [7:0] OFF_SW   = 8'h04;
  localparam logic [7:0] OFF_CNT  = 8'h08;
  localparam logic [7:0] OFF_CMP  = 8'h0C;
  localparam logic [7:0] OFF_CTRL = 8'h10;

  logic             is_mmio, mmio_wr;
  logic [7:0]       off;
  logic [31:0]      mmio_rdata;

  logic [LED_W-1:0] led_q, led_d;
  logic [SW_W-1:0]  sync1_q, sync2_q, sw_db_q, sw_db_d;
  logic [19:0]      deb_cnt_q, deb_cnt_d;
  logic [31:0]      count_q, count_d, compare_q, compare_d;
  logic             flag_q, flag_d, irq_en_q, irq_en_d, irq_q, irq_d;
  logic             flag_set, flag_clr;

  assign is_mmio      = cpu_ce_i & (cpu_addr_i[31:8] == MMIO_BASE[31:8]);
  assign mmio_wr      = is_mmio & cpu_we_i;
  assign off          = cpu_addr_i[7:0];

  assign dram_ce_o    = cpu_ce_i & ~is_mmio;
  assign dram_we_o    = dram_ce_o & cpu_we_i;
  assign dram_addr_o  = cpu_addr_i;
  assign dram_wdata_o = cpu_wdata_i;

  assign led_out      = led_q;
  assign timer_irq_o  = irq_q;

  // Reads see only registered state, so a same-cycle write returns the old value.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    mmio_rdata = '0;
    case (off)
      OFF_LED:  mmio_rdata = 32'(led_q);
      OFF_SW:   mmio_rdata = 32'(sw_db_q);
      OFF_CNT:  mmio_rdata = count_q;
      OFF_CMP:  mmio_rdata = compare_q;
      OFF_CTRL: mmio_rdata = {30'd0, irq_en_q, flag_q};
      default:  mmio_rdata = '0;
    endcase
    cpu_rdata_o = '0;
    if (cpu_ce_i) cpu_rdata_o = is_mmio ? mmio_rdata : dram_rdata_i;
  end

  always_comb begin
    led_d     = led_q;
    compare_d = compare_q;
    irq_en_d  = irq_en_q;
    count_d   = count_q + 32'd1;
    flag_clr  = 1'b0;
    if (mmio_wr) begin
      case (off)
        OFF_LED:  led_d     = cpu_wdata_i[LED_W-1:0];
        OFF_CNT:  count_d   = cpu_wdata_i;
        OFF_CMP:  compare_d = cpu_wdata_i;
        OFF_CTRL: begin
          irq_en_d = cpu_wdata_i[1];
          flag_clr = cpu_wdata_i[0];
        end
        default: ;
      endcase
    end
    // Match on the value COUNT is about to take so the flag rises with it; set wins.
    flag_set = (count_d == compare_q);
    flag_d   = flag_set | (flag_q & ~flag_clr);
    irq_d    = flag_d & irq_en_d;
  end

  // Any bounce while the count runs clears it, so only an uninterrupted change is accepted.
  always_comb begin
    sw_db_d   = sw_db_q;
    deb_cnt_d = '0;
    if (sync2_q != sw_db_q) begin
      if (deb_cnt_q == DEB_CYC - 20'd1) sw_db_d = sync2_q;
      else                              deb_cnt_d = deb_cnt_q + 20'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q     <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      sw_db_q   <= '0;
      deb_cnt_q <= '0;
      count_q   <= '0;
      compare_q <= 32'hFFFF_FFFF;
      flag_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      led_q     <= led_d;
      sync1_q   <= switch_on;
      sync2_q   <= sync1_q;
      sw_db_q   <= sw_db_d;
      deb_cnt_q <= deb_cnt_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      flag_q    <= flag_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// Scoreboard bench for mmio_bridge: stimulus queues expected values per cycle,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_mmio_bridge;

  localparam logic [31:0] BASE = 32'hBFAF_F000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_ce, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dram_ce, dram_we;
  logic [31:0] dram_addr, dram_wdata, dram_rdata;
  logic [15:0] switch_on, led_out;
  logic        timer_irq;

  mmio_bridge #(.SW_W(16), .LED_W(16), .DEB_CYC(20'd4), .MMIO_BASE(BASE)) dut (
    .clk(clk), .rst(rst_n),
    .cpu_ce_i(cpu_ce), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata),
    .dram_ce_o(dram_ce), .dram_we_o(dram_we), .dram_addr_o(dram_addr),
    .dram_wdata_o(dram_wdata), .dram_rdata_i(dram_rdata),
    .switch_on(switch_on), .led_out(led_out), .timer_irq_o(timer_irq)
  );

  always #5 clk = ~clk;

  typedef enum {K_RDATA, K_DCE, K_DWE, K_DADDR, K_DWDATA, K_LED, K_IRQ} kind_e;
  typedef struct {
    int          cyc;
    kind_e       kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(input kind_e k);
    case (k)
      K_RDATA:  return cpu_rdata;
      K_DCE:    return {31'd0, dram_ce};
      K_DWE:    return {31'd0, dram_we};
      K_DADDR:  return dram_addr;
      K_DWDATA: return dram_wdata;
      K_LED:    return {16'd0, led_out};
      default:  return {31'd0, timer_irq};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name, sample(e.kind), e.exp);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ce, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    cpu_ce = ce; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic exp_push(input kind_e k, input logic [31:0] v, input string name);
    sb.push_back('{cyc, k, v, name});
  endtask

  // One cycle: drive an MMIO read at offset and expect rdata plus irq.
  task automatic mmio_rd(input logic [7:0] off, input logic [31:0] v, input logic irq,
                         input string name);
    step();
    drive(1'b1, 1'b0, BASE | {24'd0, off}, 32'd0);
    exp_push(K_RDATA, v, name);
    exp_push(K_IRQ, {31'd0, irq}, {name, "_irq"});
  endtask

  // One cycle: MMIO write; rdata shows the pre-write register value.
  task automatic mmio_wr(input logic [7:0] off, input logic [31:0] wd, input logic [31:0] old_v,
                         input string name);
    step();
    drive(1'b1, 1'b1, BASE | {24'd0, off}, wd);
    exp_push(K_RDATA, old_v, name);
    exp_push(K_DCE, 32'd0, {name, "_dce"});
  endtask

  initial begin
    rst_n = 1'b0; drive(1'b0, 1'b0, 32'd0, 32'd0);
    dram_rdata = 32'd0; switch_on = 16'd0;

    // Reset state
    step();
    exp_push(K_RDATA, 32'd0, "rst_rdata_idle");
    exp_push(K_LED, 32'd0, "rst_led");
    exp_push(K_IRQ, 32'd0, "rst_irq");
    mmio_rd(8'h0C, 32'hFFFF_FFFF, 1'b0, "rst_compare");
    mmio_rd(8'h10, 32'd0, 1'b0, "rst_ctrl");
    step(); rst_n = 1'b1; drive(1'b0, 1'b0, 32'd0, 32'd0);

    // 1: LED write then read
    mmio_wr(8'h00, 32'h0000_A5A5, 32'd0, "led_wr");
    exp_push(K_LED, 32'd0, "led_out_before");
    mmio_rd(8'h00, 32'h0000_A5A5, 1'b0, "led_rd");
    exp_push(K_LED, 32'h0000_A5A5, "led_out_after");
    exp_push(K_DCE, 32'd0, "led_rd_dce");

    // 2: RAM passthrough
    step(); drive(1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678);
    exp_push(K_DCE, 32'd1, "ram_wr_ce");
    exp_push(K_DWE, 32'd1, "ram_wr_we");
    exp_push(K_DADDR, 32'h0000_0040, "ram_wr_addr");
    exp_push(K_DWDATA, 32'h1234_5678, "ram_wr_data");
    step(); drive(1'b1, 1'b0, 32'h0000_0040, 32'd0); dram_rdata = 32'hDEAD_BEEF;
    exp_push(K_RDATA, 32'hDEAD_BEEF, "ram_rd_data");
    exp_push(K_DCE, 32'd1, "ram_rd_ce");
    exp_push(K_DWE, 32'd0, "ram_rd_we");
    step(); drive(1'b0, 1'b1, 32'h0000_0040, 32'd0);
    exp_push(K_RDATA, 32'd0, "idle_rdata");
    exp_push(K_DCE, 32'd0, "idle_dce");
    exp_push(K_DWE, 32'd0, "idle_dwe");
    dram_rdata = 32'd0;

    // 3: debounce, acceptance after 2 + DEB_CYC = 6 edges
    mmio_rd(8'h04, 32'd0, 1'b0, "sw_t0");
    switch_on = 16'h0001;
    for (int i = 1; i <= 6; i++)
      mmio_rd(8'h04, (i >= 6) ? 32'd1 : 32'd0, 1'b0, $sformatf("sw_t%0d", i));
    mmio_rd(8'h04, 32'd1, 1'b0, "sw_glitch0");
    switch_on = 16'h0003;
    mmio_rd(8'h04, 32'd1, 1'b0, "sw_glitch1");
    mmio_rd(8'h04, 32'd1, 1'b0, "sw_glitch2");
    switch_on = 16'h0001;
    for (int i = 3; i < 12; i++)
      mmio_rd(8'h04, 32'd1, 1'b0, $sformatf("sw_glitch%0d", i));

    // 4: timer compare, sticky flag, W1C
    mmio_wr(8'h0C, 32'd20, 32'hFFFF_FFFF, "cmp_wr");
    mmio_wr(8'h08, 32'd15, 32'hx, "cnt_wr");
    sb.delete(sb.size() - 2);  // running count value is not tracked here
    mmio_wr(8'h10, 32'd2, 32'd0, "ctrl_wr_en");
    for (int i = 16; i < 20; i++)
      mmio_rd(8'h08, i, 1'b0, $sformatf("cnt_%0d", i));
    mmio_rd(8'h10, 32'd3, 1'b1, "flag_at_match");
    mmio_rd(8'h08, 32'd21, 1'b1, "cnt_21_sticky");
    mmio_rd(8'h08, 32'd22, 1'b1, "cnt_22_sticky");
    mmio_wr(8'h10, 32'd3, 32'd3, "ctrl_w1c");
    mmio_rd(8'h10, 32'd2, 1'b0, "flag_cleared");

    // 5: wrap match, set beats clear
    mmio_wr(8'h0C, 32'd0, 32'd20, "cmp_wr0");
    mmio_wr(8'h08, 32'hFFFF_FFFE, 32'hx, "cnt_wr_fffe");
    sb.delete(sb.size() - 2);
    mmio_rd(8'h08, 32'hFFFF_FFFE, 1'b0, "cnt_fffe");
    mmio_wr(8'h10, 32'd3, 32'd2, "w1c_in_set_cycle");
    exp_push(K_IRQ, 32'd0, "irq_before_wrap");
    mmio_rd(8'h10, 32'd3, 1'b1, "flag_set_wins");
    mmio_rd(8'h08, 32'd1, 1'b1, "cnt_after_wrap");

    // 6: async reset mid-debounce with flag set
    switch_on = 16'h0000;
    mmio_rd(8'h04, 32'd1, 1'b1, "sw_pre_rst0");
    mmio_rd(8'h04, 32'd1, 1'b1, "sw_pre_rst1");
    mmio_rd(8'h04, 32'd1, 1'b1, "sw_pre_rst2");
    step(); rst_n = 1'b0; drive(1'b1, 1'b0, BASE | 32'h10, 32'd0);
    exp_push(K_RDATA, 32'd0, "rst_async_ctrl");
    exp_push(K_IRQ, 32'd0, "rst_async_irq");
    exp_push(K_LED, 32'd0, "rst_async_led");
    mmio_rd(8'h04, 32'd0, 1'b0, "rst_sw");
    mmio_rd(8'h0C, 32'hFFFF_FFFF, 1'b0, "rst_cmp");
    step(); rst_n = 1'b1; drive(1'b1, 1'b0, BASE | 32'h08, 32'd0);
    exp_push(K_RDATA, 32'd0, "cnt_at_release");
    mmio_rd(8'h08, 32'd1, 1'b0, "cnt_after_release");
    mmio_wr(8'h14, 32'hFFFF_FFFF, 32'd0, "wr_unmapped");
    mmio_rd(8'h14, 32'd0, 1'b0, "rd_unmapped");
    mmio_wr(8'h04, 32'h0000_FFFF, 32'd0, "wr_switch_ro");
    mmio_rd(8'h04, 32'd0, 1'b0, "rd_switch_ro");
    mmio_rd(8'h00, 32'd0, 1'b0, "rd_led_after_rst");

    step(); drive(1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 20 && sb.size() > 0; i++) step();
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
